// File: rtl/axi_arb_pkg.sv
// Shared types and round-robin helpers for the burst arbiter.
// Helpers take the requester count explicitly so one package serves any N_REQ up to MAX_REQ.
package axi_arb_pkg;

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_e;

    localparam int MAX_REQ = 32;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr < n - 1) ? ptr + 1 : 0;
    endfunction

    // First valid index scanning ptr, ptr+1, ... mod n; ptr itself when nothing is valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && !found) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (valid[idx[4:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_rr_pointer.sv
// Round-robin priority pointer: loads next(cur) when adv is set, one-cycle update.
// No backpressure of its own; the owner decides when a transfer counts.
module axi_rr_pointer
    import axi_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic [ID_W-1:0] cur,
    output logic [ID_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ID_W'(rr_next(int'(cur), N_REQ));
        end
    end

endmodule

// File: rtl/axi_rr_burst_arbiter.sv
// N-to-1 round-robin valid/ready arbiter, zero-latency mux; grant held across stalls and, with
// AXI_RR_BURST_LOCK_EN defined, across whole bursts (first beat through last).
module axi_rr_burst_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic                    out_last_o,
    output logic [ID_W-1:0]         out_id_o,
    input  logic                    out_ready_i,
    output logic [ID_W-1:0]         rr_ptr_o
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] hold_id;
    logic            hold_vld;
    logic            hs;
    logic            adv;
    logic            arb_state;

`ifdef AXI_RR_BURST_LOCK_EN
    arb_state_e      state;
    logic [ID_W-1:0] lock_id;
    assign arb_state = (state == ARB);
`else
    assign arb_state = 1'b1;
`endif

    always_comb begin
        sel = ID_W'(rr_pick(MAX_REQ'(req_valid_i), int'(rr_ptr), N_REQ));
`ifdef AXI_RR_BURST_LOCK_EN
        if (state == LOCK)  sel = lock_id;
        else if (hold_vld)  sel = hold_id;
`else
        if (hold_vld)       sel = hold_id;
`endif
    end

    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        req_ready_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel == ID_W'(k)) begin
                out_valid_o    = req_valid_i[k];
                out_data_o     = req_valid_i[k] ? req_data_i[k*DATA_W +: DATA_W] : '0;
                out_last_o     = req_valid_i[k] & req_last_i[k];
                req_ready_o[k] = out_ready_i;
            end
        end
    end

    assign out_id_o = sel;
    assign hs       = out_valid_o & out_ready_i;
    assign rr_ptr_o = rr_ptr;

    // Inside a burst sel is lock_id, so next(sel) covers both the ARB and LOCK advance cases.
`ifdef AXI_RR_BURST_LOCK_EN
    assign adv = hs & out_last_o;
`else
    assign adv = hs;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold_id  <= '0;
`ifdef AXI_RR_BURST_LOCK_EN
            state    <= ARB;
            lock_id  <= '0;
`endif
        end else begin
            if (hs) begin
                hold_vld <= 1'b0;
            end else if (out_valid_o && !out_ready_i && arb_state) begin
                hold_vld <= 1'b1;
                hold_id  <= sel;
            end
`ifdef AXI_RR_BURST_LOCK_EN
            case (state)
                ARB: if (hs && !out_last_o) begin
                    state   <= LOCK;
                    lock_id <= sel;
                end
                LOCK: if (hs && out_last_o) state <= ARB;
                default: state <= ARB;
            endcase
`endif
        end
    end

    axi_rr_pointer #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_ptr (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .cur (sel),
        .ptr (rr_ptr)
    );

endmodule

// File: tb/tb_axi_rr_burst_arbiter.sv
// Directed and random stimulus for axi_rr_burst_arbiter against a grant-ownership model.
module tb_axi_rr_burst_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_id;
    logic            out_ready;
    logic [1:0]      rr_ptr;

    int checks = 0;
    int errors = 0;

    // Model: owner of the grant, -1 when nobody owns it.
    int m_ptr  = 0;
    int m_lock = -1;
    int m_hold = -1;

    axi_rr_burst_arbiter #(.N_REQ(N), .ID_W(2), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_id_o    (out_id),
        .out_ready_i (out_ready),
        .rr_ptr_o    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int x);
        return (x < N - 1) ? x + 1 : 0;
    endfunction

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic rdy, input logic [N*DW-1:0] d, input int eid, input int eptr);
        int       s;
        logic     ev, el, found, hs;
        logic [DW-1:0] ed;
        logic [N-1:0]  er;
        rst = r; req_valid = v; req_last = l; out_ready = rdy; req_data = d;
        #2;
        if (m_lock >= 0)      s = m_lock;
        else if (m_hold >= 0) s = m_hold;
        else begin
            s = m_ptr;
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && v[(m_ptr + i) % N]) begin
                    s = (m_ptr + i) % N;
                    found = 1'b1;
                end
            end
        end
        ev = v[s];
        ed = ev ? DW'(d >> (DW * s)) : '0;
        el = ev ? l[s] : 1'b0;
        er = rdy ? N'(1 << s) : '0;
        chk("out_valid", 128'(out_valid), 128'(ev));
        chk("out_id",    128'(out_id),    128'(s));
        chk("out_data",  128'(out_data),  128'(ed));
        chk("out_last",  128'(out_last),  128'(el));
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("rr_ptr",    128'(rr_ptr),    128'(m_ptr));
        if (eid >= 0)  chk("dir_id",  128'(out_id), 128'(eid));
        if (eptr >= 0) chk("dir_ptr", 128'(rr_ptr), 128'(eptr));
        hs = ev && rdy;
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_lock = -1; m_hold = -1;
        end else if (hs) begin
            m_hold = -1;
`ifdef AXI_RR_BURST_LOCK_EN
            if (el) begin
                m_ptr  = nxt(s);
                m_lock = -1;
            end else begin
                m_lock = s;
            end
`else
            m_ptr = nxt(s);
`endif
        end else if (ev && m_lock < 0) begin
            m_hold = s;
        end
        #1;
    endtask

    logic [N*DW-1:0] dd;
    logic [N*DW-1:0] rd;

    initial begin
        dd = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
        rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, nothing valid.
        cyc(0, 4'b0000, 4'b0000, 1, dd, 0, 0);

        // All valid single beats: grants rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) cyc(0, 4'b1111, 4'b1111, 1, dd, i % 4, i % 4);
        cyc(0, 4'b0010, 4'b0010, 1, dd, 1, 1);

        // Pointer at 2 skips to 3, wraps to 0.
        cyc(0, 4'b1011, 4'b1111, 1, dd, 3, 2);
        cyc(0, 4'b0011, 4'b1111, 1, dd, 0, 0);

        // Stall hold on requester 0 while 3 rises.
        cyc(0, 4'b0001, 4'b1111, 0, dd, 0, 1);
        cyc(0, 4'b1001, 4'b1111, 0, dd, 0, 1);
        cyc(0, 4'b1001, 4'b1111, 0, dd, 0, 1);
        cyc(0, 4'b1001, 4'b1111, 1, dd, 0, 1);

        // Requester 1 three-beat burst with requester 2 waiting.
`ifdef AXI_RR_BURST_LOCK_EN
        cyc(0, 4'b0110, 4'b0100, 1, dd, 1, 1);
        cyc(0, 4'b0110, 4'b0100, 1, dd, 1, 1);
        cyc(0, 4'b0110, 4'b0110, 1, dd, 1, 1);
        cyc(0, 4'b0100, 4'b0100, 1, dd, 2, 2);
`else
        cyc(0, 4'b0110, 4'b0100, 1, dd, 1, 1);
        cyc(0, 4'b0110, 4'b0100, 1, dd, 2, 2);
        cyc(0, 4'b0110, 4'b0110, 1, dd, 1, 3);
        cyc(0, 4'b0100, 4'b0100, 1, dd, 2, 2);
`endif

        // Reset in the middle of a burst owned by requester 2.
        cyc(0, 4'b0100, 4'b0000, 1, dd, 2, -1);
        cyc(1, 4'b0101, 4'b0000, 1, dd, -1, -1);
        cyc(0, 4'b0101, 4'b0001, 1, dd, 0, 0);

        // Two 2-beat bursts from requesters 0 and 1.
        cyc(1, 4'b0000, 4'b0000, 1, dd, -1, -1);
`ifdef AXI_RR_BURST_LOCK_EN
        cyc(0, 4'b0011, 4'b0000, 1, dd, 0, 0);
        cyc(0, 4'b0011, 4'b0001, 1, dd, 0, 0);
        cyc(0, 4'b0011, 4'b0011, 1, dd, 1, 1);
        cyc(0, 4'b0010, 4'b0010, 1, dd, 1, 2);
`else
        cyc(0, 4'b0011, 4'b0000, 1, dd, 0, 0);
        cyc(0, 4'b0011, 4'b0001, 1, dd, 1, 1);
        cyc(0, 4'b0011, 4'b0011, 1, dd, 0, 2);
        cyc(0, 4'b0010, 4'b0010, 1, dd, 1, 1);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            cyc(($urandom_range(0, 49) == 0), N'($urandom), N'($urandom),
                ($urandom_range(0, 3) != 0), rd, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
